// File: rtl/hier_mac_pkg.sv
// Shared types and constants for the hier_mac_pipe datapath.
// The optional accumulator is enabled by defining HIER_MAC_ACC_EN.
package hier_mac_pkg;

  typedef enum logic [1:0] {
    OP_MAC  = 2'b00,
    OP_ADD3 = 2'b01,
    OP_MSUB = 2'b10,
    OP_ACC  = 2'b11
  } op_e;

  localparam int MIN_STAGES = 2;
  localparam int DEF_WIDTH  = 32;

  // Per-lane result as seen by a consumer at the default lane width.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] val;
    logic                 ovf;
  } lane_res_t;

endpackage

// File: rtl/hier_mac_lane.sv
// Combinational per-lane arithmetic: a*b+c, a+b+c, a*b-c and, with
// HIER_MAC_ACC_EN defined, acc+a*b. Results wrap mod 2^WIDTH with an exactness flag.
module hier_mac_lane
  import hier_mac_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
`ifdef HIER_MAC_ACC_EN
  input  logic [WIDTH-1:0] acc,
`endif
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] val,
  output logic             ovf
);

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH:0]   mac_sum;
  logic [WIDTH+1:0]   add3;
  logic [WIDTH-1:0]   addend;
  logic               borrow;

  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

`ifdef HIER_MAC_ACC_EN
  assign addend = (op_e'(op) == OP_ACC) ? acc : c;
`else
  assign addend = c;
`endif

  assign mac_sum = {1'b0, prod} + {{(WIDTH + 1){1'b0}}, addend};
  assign add3    = {2'b00, a} + {2'b00, b} + {2'b00, c};
  assign borrow  = prod < {{WIDTH{1'b0}}, c};

  // Multiply-add is the default so op 11 folds onto it when no accumulator exists.
  always_comb begin
    val = mac_sum[WIDTH-1:0];
    ovf = |mac_sum[2*WIDTH:WIDTH];
    case (op_e'(op))
      OP_ADD3: begin
        val = add3[WIDTH-1:0];
        ovf = |add3[WIDTH+1:WIDTH];
      end
      OP_MSUB: begin
        val = prod[WIDTH-1:0] - c;
        ovf = borrow;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hier_mac_pipe.sv
// Elastic multi-lane MAC pipeline: valid/ready control, stage registers and
// the optional per-lane accumulator (enabled by defining HIER_MAC_ACC_EN).
module hier_mac_pipe
  import hier_mac_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LANES  = 1,
  parameter int STAGES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             op,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  input  logic [LANES*WIDTH-1:0] c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] result,
  output logic [LANES-1:0]       overflow
);

  localparam int NSTG = (STAGES < MIN_STAGES) ? MIN_STAGES : STAGES;
  localparam int DW   = LANES * WIDTH;

  // Handshake: a beat moves on an edge where valid && ready on that side;
  // stage k loads when it is empty or its successor loads, so bubbles collapse.
  logic [NSTG-1:0]  v;
  logic [NSTG-1:0]  adv;
  logic [DW-1:0]    a_q, b_q, c_q;
  logic [1:0]       op_q;
  logic [DW-1:0]    res_q [1:NSTG-1];
  logic [LANES-1:0] ovf_q [1:NSTG-1];
  logic [DW-1:0]    lane_val;
  logic [LANES-1:0] lane_ovf;
`ifdef HIER_MAC_ACC_EN
  logic [DW-1:0]    acc_q;
`endif

  // Stage k advances when any stage from k to the output is empty or the sink pops.
  always_comb begin
    logic full;
    full = 1'b1;
    adv  = '0;
    for (int k = NSTG - 1; k >= 0; k--) begin
      full   = full & v[k];
      adv[k] = out_ready | ~full;
    end
  end

  assign in_ready  = rst_n & adv[0];
  assign out_valid = v[NSTG-1];
  assign result    = res_q[NSTG-1];
  assign overflow  = ovf_q[NSTG-1];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    hier_mac_lane #(.WIDTH(WIDTH)) u_lane (
      .a   (a_q[i*WIDTH +: WIDTH]),
      .b   (b_q[i*WIDTH +: WIDTH]),
      .c   (c_q[i*WIDTH +: WIDTH]),
`ifdef HIER_MAC_ACC_EN
      .acc (acc_q[i*WIDTH +: WIDTH]),
`endif
      .op  (op_q),
      .val (lane_val[i*WIDTH +: WIDTH]),
      .ovf (lane_ovf[i])
    );
  end

  // Data registers load only with a valid beat to keep idle toggling down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v    <= '0;
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= '0;
      op_q <= '0;
      for (int k = 1; k < NSTG; k++) begin
        res_q[k] <= '0;
        ovf_q[k] <= '0;
      end
    end else begin
      if (adv[0]) begin
        v[0] <= in_valid;
        if (in_valid) begin
          a_q  <= a;
          b_q  <= b;
          c_q  <= c;
          op_q <= op;
        end
      end
      if (adv[1]) begin
        v[1] <= v[0];
        if (v[0]) begin
          res_q[1] <= lane_val;
          ovf_q[1] <= lane_ovf;
        end
      end
      for (int k = 2; k < NSTG; k++) begin
        if (adv[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) begin
            res_q[k] <= res_q[k-1];
            ovf_q[k] <= ovf_q[k-1];
          end
        end
      end
    end
  end

`ifdef HIER_MAC_ACC_EN
  // The accumulator takes the new value on the same edge stage 1 captures it,
  // so the next op-11 beat in stage 0 already sees the updated sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (adv[1] && v[0] && (op_q == OP_ACC)) begin
      acc_q <= lane_val;
    end
  end
`endif

endmodule

// File: tb/tb_hier_mac_pipe.sv
// Bench for hier_mac_pipe (two lanes, default width and depth): directed table,
// backpressure, mid-stream reset, accumulator chain and randomised traffic.
module tb_hier_mac_pipe;
  import hier_mac_pkg::*;

  localparam int W  = 32;
  localparam int L  = 2;
  localparam int S  = 3;
  localparam int DW = L * W;
  localparam int EW = DW + L;
`ifdef HIER_MAC_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic          clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]    op;
  logic [DW-1:0] a, b, c, result;
  logic [L-1:0]  overflow;

  hier_mac_pipe #(.WIDTH(W), .LANES(L), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, c, res;
    logic         ovf;
  } vec_t;

  vec_t          tbl [12];
  logic [EW-1:0] exp_q [$];
  int            pop_log [$];
  int            n_vec, n_fail, cyc, push_cnt, pop_cnt, acc_cyc, pop_cyc, ready_mode, win;
  bit            accepted, stall_prev;
  logic [EW-1:0] held, pend_exp;
  logic [L-1:0]  pend_mask;
  logic [W-1:0]  model_acc [L];

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic lane_res_t ref_lane(input logic [1:0] o, input logic [W-1:0] x, y, z, acc);
    logic [127:0] wx, wy, wz, wacc, prod, r, lim;
    lane_res_t    res;
    wx = x; wy = y; wz = z; wacc = acc;
    prod = wx * wy;
    lim  = 128'd1 << W;
    case (o)
      2'b01:   begin r = wx + wy + wz; res.ovf = (r >= lim); end
      2'b10:   begin r = prod - wz;    res.ovf = (prod < wz); end
      2'b11:   begin
        r = ACC_EN ? prod + wacc : prod + wz;
        res.ovf = (r >= lim);
      end
      default: begin r = prod + wz;    res.ovf = (r >= lim); end
    endcase
    res.val = r[W-1:0];
    return res;
  endfunction

  function automatic logic [EW-1:0] model_beat(input logic [1:0] o, input logic [DW-1:0] x, y, z);
    logic [EW-1:0] w;
    lane_res_t     r;
    w = '0;
    for (int l = 0; l < L; l++) begin
      r = ref_lane(o, x[l*W +: W], y[l*W +: W], z[l*W +: W], model_acc[l]);
      w[l*W +: W] = r.val;
      w[DW + l]   = r.ovf;
      if (ACC_EN && o == 2'b11) model_acc[l] = r.val;
    end
    return w;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return W'($urandom_range(0, 255));
      2:       return 32'hFFFF_FFFF - W'($urandom_range(0, 3));
      default: return W'($urandom_range(0, 65535));
    endcase
  endfunction

  function automatic logic [DW-1:0] rnd_vec();
    logic [DW-1:0] v;
    for (int l = 0; l < L; l++) v[l*W +: W] = rnd_word();
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_mode(input int m);
    ready_mode = m;
    win = 0;
    case (m)
      1:       out_ready = ($urandom_range(0, 3) != 0);
      3:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  endtask

  // One clock: sample outputs and handshakes at the falling edge, then
  // update inputs 1 ns after the rising edge.
  task automatic step();
    logic [EW-1:0] w;
    @(negedge clk);
    if (rst_n) begin
      if (stall_prev) check("hold_stable", {out_valid, overflow, result}, {1'b1, held});
      if (out_valid && out_ready) begin
        pop_cnt++;
        pop_cyc = cyc;
        pop_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_beat: actual %0h required none", {overflow, result});
        end else begin
          w = exp_q.pop_front();
          check("result", {overflow, result}, w);
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = {overflow, result};
      if (in_valid && in_ready) begin
        w = model_beat(op, a, b, c);
        for (int l = 0; l < L; l++) begin
          if (pend_mask[l]) begin
            w[l*W +: W] = pend_exp[l*W +: W];
            w[DW + l]   = pend_exp[DW + l];
          end
        end
        exp_q.push_back(w);
        push_cnt++;
        acc_cyc  = cyc + 1;
        accepted = 1'b1;
      end
      if (ready_mode == 2 && win == 7) begin
        check("full_in_ready", in_ready, 0);
        check("full_depth", push_cnt - pop_cnt, S);
      end
    end else begin
      stall_prev = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    win++;
    case (ready_mode)
      1:       out_ready = ($urandom_range(0, 3) != 0);
      2:       out_ready = !(win >= 4 && win <= 9);
      3:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic [1:0] o, input logic [DW-1:0] x, y, z);
    op = o; a = x; b = y; c = z;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int t = 0; t < 64 && !accepted; t++) step();
    if (!accepted) begin
      n_vec++;
      n_fail++;
      $display("FAIL send_timeout: actual not accepted required accepted");
    end
    in_valid  = 1'b0;
    pend_mask = '0;
  endtask

  task automatic apply_vec(input int i);
    pend_mask = 2'b01;
    pend_exp  = {1'b0, tbl[i].ovf, W'(0), tbl[i].res};
    send(tbl[i].op, {rnd_word(), tbl[i].a}, {rnd_word(), tbl[i].b}, {rnd_word(), tbl[i].c});
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int t = 0; t < 400 && exp_q.size() != 0; t++) step();
    check("drain_empty", exp_q.size(), 0);
    repeat (4) step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_vec = 0; n_fail = 0; cyc = 0; push_cnt = 0; pop_cnt = 0; acc_cyc = 0; pop_cyc = 0;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; c = '0;
    out_ready = 1'b1; ready_mode = 0; win = 0; pend_mask = '0; pend_exp = '0;
    stall_prev = 1'b0; held = '0; accepted = 1'b0;
    for (int l = 0; l < L; l++) model_acc[l] = '0;

    tbl[0]  = '{2'b00, 32'd2,          32'd2,          32'd2,     32'd6,          1'b0};
    tbl[1]  = '{2'b00, 32'd200,        32'd4,          32'd15,    32'd815,        1'b0};
    tbl[2]  = '{2'b01, 32'd7898,       32'd91,         32'd10202, 32'd18191,      1'b0};
    tbl[3]  = '{2'b00, 32'hFFFF_FFFF,  32'd2,          32'd0,     32'hFFFF_FFFE,  1'b1};
    tbl[4]  = '{2'b10, 32'd898,        32'd29,         32'd0,     32'd26042,      1'b0};
    tbl[5]  = '{2'b10, 32'd0,          32'd0,          32'd1,     32'hFFFF_FFFF,  1'b1};
    tbl[6]  = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd2,     32'd0,          1'b1};
    tbl[7]  = '{2'b11, 32'd3,          32'd4,          32'd5,     ACC_EN ? 32'd12 : 32'd17, 1'b0};
    tbl[8]  = '{2'b00, 32'd0,          32'd0,          32'd0,     32'd0,          1'b0};
    tbl[9]  = '{2'b01, 32'hFFFF_FFFE,  32'd1,          32'd0,     32'hFFFF_FFFF,  1'b0};
    tbl[10] = '{2'b00, 32'd65536,      32'd65536,      32'd0,     32'd0,          1'b1};
    tbl[11] = '{2'b10, 32'd5,          32'd5,          32'd25,    32'd0,          1'b0};

    // Reset values
    repeat (2) step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_overflow", overflow, 0);
    repeat (14) step();
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);

    // Latency of a lone beat, then the directed table back to back
    apply_vec(0);
    drain();
    check("latency", pop_cyc - acc_cyc, S - 1);
    for (int i = 1; i < 12; i++) apply_vec(i);
    drain();

    // Backpressure: out_ready low for window cycles 4..9
    set_mode(2);
    for (int i = 0; i < 32; i++) send(2'b00, {L{W'(i)}}, {L{W'(i)}}, {L{W'(i)}});
    drain();
    set_mode(0);

    // Randomised traffic with random backpressure
    set_mode(1);
    repeat (300) send(2'($urandom_range(0, 3)), rnd_vec(), rnd_vec(), rnd_vec());
    set_mode(0);
    drain();

    // Reset with three beats held in flight
    set_mode(3);
    for (int i = 0; i < 3; i++) send(2'b00, {L{W'(50 + i)}}, {L{W'(3)}}, {L{W'(1)}});
    check("pre_rst_out_valid", out_valid, 1);
    check("pre_rst_depth", push_cnt - pop_cnt, S);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_overflow", overflow, 0);
    exp_q.delete();
    for (int l = 0; l < L; l++) model_acc[l] = '0;
    push_cnt = 0;
    pop_cnt  = 0;
    repeat (3) step();
    rst_n = 1'b1;
    set_mode(0);
    for (int i = 0; i < 4; i++) send(2'b00, {L{W'(100 + i)}}, {L{W'(100 + i)}}, {L{W'(100 + i)}});
    drain();
    check("post_rst_beats", pop_cnt, 4);

    // Accumulator chain: lane0 (3,4), lane1 (1,1), c = 0, back to back
    pop_log.delete();
    for (int j = 1; j <= 3; j++) begin
      pend_mask = 2'b11;
      pend_exp  = {2'b00, W'(ACC_EN ? j : 1), W'(ACC_EN ? 12 * j : 12)};
      send(2'b11, {W'(1), W'(3)}, {W'(1), W'(4)}, '0);
    end
    drain();
    check("acc_pops", pop_log.size(), 3);
    if (pop_log.size() == 3) begin
      check("acc_gap1", pop_log[1] - pop_log[0], 1);
      check("acc_gap2", pop_log[2] - pop_log[1], 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/hier_mac_pipe.md
Name: hier_mac_pipe

Overview:
Parametrised, elastic multiply-accumulate datapath computing a per-lane three-operand function of a, b and c. It is built as top-level pipeline control around per-lane arithmetic sub-modules, so power traces resolve per hierarchy level. Valid/ready handshakes on both sides. It is a drop-in example design for hierarchical power-analysis runs, scaled by width, lane count and pipeline depth.

Parameters:
WIDTH, 32, operand/result width per lane in bits (>=4)
LANES, 1, number of independent parallel lanes (>=1)
STAGES, 3, pipeline register stages from input accept to output (>=2)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept the input beat
op  input  2  operation: 00 a*b+c, 01 a+b+c, 10 a*b-c, 11 see Optional Feature
a  input  LANES*WIDTH  operand A, lane i at bits [i*WIDTH +: WIDTH]
b  input  LANES*WIDTH  operand B, same packing
c  input  LANES*WIDTH  operand C, same packing
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts the result beat
result  output  LANES*WIDTH  per-lane result, modulo 2^WIDTH
overflow  output  LANES  per-lane flag: result was not exact in WIDTH bits (unsigned)

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits = 0, out_valid = 0, result = 0, overflow = 0. in_ready = 0 while rst_n is low.
- Stage k has a valid bit v[k]. Stage k advances when !v[k] || adv[k+1]. The last stage advances when !out_valid || out_ready. in_ready = adv[0], combinational, with no path from in_valid.
- An input beat is accepted when in_valid && in_ready. Stage 0 registers a, b, c and op.
- Stage 1 computes in hier_mac_lane at full precision: the product is 2*WIDTH bits, the sum keeps extra carry bits. Stages 2..STAGES-1 delay the result and flag unchanged.
- Latency: accept at edge N gives out_valid=1 after edge N+STAGES-1, so the result is visible in cycle N+STAGES. Throughput is 1 beat/cycle when out_ready=1.
- Backpressure: while out_valid && !out_ready, result and overflow are held stable. Bubbles collapse, so a full pipeline holds exactly STAGES beats. Order is preserved and no beat is lost or duplicated.
- A simultaneous output pop and input push on a full pipeline is allowed: in_ready=1 in that cycle.
- Arithmetic is unsigned. result = exact value mod 2^WIDTH.
- overflow=1 if any discarded high bit is nonzero (op 00/01), or on borrow when a*b < c (op 10).
- Reset mid-operation drops every in-flight beat immediately. The first output after rst_n rises comes only from a beat accepted after the release.

Optional Feature:
HIER_MAC_ACC_EN
- Defined: adds a per-lane WIDTH-bit accumulator acc, reset to 0. op=11 computes result = acc + a*b (mod 2^WIDTH), with overflow per op-00 rules.
- acc is updated to the new result when the op-11 beat leaves stage 1, so back-to-back op-11 beats chain without stalls. Other ops do not touch acc.
- Undefined: no accumulator; op=11 behaves exactly as op=00.

Decomposition:
- Package hier_mac_pkg holds: the op_e enum (OP_MAC, OP_ADD3, OP_MSUB, OP_ACC), the localparam for the minimum STAGES, and a lane_res_t struct {logic [WIDTH-1:0] val; logic ovf;} parametrised via the WIDTH default.
- Sub-module hier_mac_lane: combinational per-lane arithmetic plus overflow, instantiated LANES times with generate.
- The top level owns the valid/ready pipeline, stage registers and the optional accumulator.

Test Plan:
- Defaults, out_ready=1: reset 16 cycles, then op00 a=2,b=2,c=2 -> result 6, overflow 0, out_valid in cycle accept+3. a=200,b=4,c=15 -> 815.
- op01 a=7898,b=91,c=10202 -> 18191, overflow 0. op00 a=0xFFFF_FFFF,b=2,c=0 -> 0xFFFF_FFFE, overflow 1.
- op10 a=898,b=29,c=0 -> 26042, overflow 0. op10 a=0,b=0,c=1 -> 0xFFFF_FFFF, overflow 1.
- Backpressure: stream 32 beats (a=i,b=i,c=i), out_ready low for cycles 4-9.
  - in_ready drops after 3 beats are held.
  - result stays stable while stalled.
  - all 32 results i*i+i arrive in order.
- Reset mid-stream with 3 beats in flight -> out_valid=0 immediately. After release, only newly accepted beats appear.
- With HIER_MAC_ACC_EN, LANES=2: op11 (a,b)=(3,4) three times, lane1 (1,1) -> lane0 12, 24, 36 and lane1 1, 2, 3 on consecutive cycles.
